// File: rtl/mipi_tx_arbiter_if.sv
// mipi_tx_arbiter_if
//   Bundles the requester handshakes, the line-valid pacing input and the
//   TX-side outputs of mipi_tx_arbiter.
//   master : payload producers + timing generator side (drives req/data/line_valid)
//   slave  : arbiter side (drives ack, tx_data, status)
//   req0/req1     : requests, held until the matching ack
//   data0/data1   : DLEN-byte payloads, byte i at [8i+7:8i]
//   line_valid    : a word is consumed on each edge where this is 1
//   ack0/ack1     : one-cycle payload-latched pulse
//   tx_data       : 64-bit word to the MIPI TX, [63:48] always 0
//   tx_busy       : packet in flight
//   tx_owner      : current/last granted requester
//   done          : one-cycle pulse after the last data word
//   pkt_cnt       : completed packet count (wraps)
interface mipi_tx_arbiter_if #(
   parameter int DLEN = 512
) ();
   logic                req0;
   logic                req1;
   logic [DLEN*8-1:0]   data0;
   logic [DLEN*8-1:0]   data1;
   logic                line_valid;
   logic                ack0;
   logic                ack1;
   logic [63:0]         tx_data;
   logic                tx_busy;
   logic                tx_owner;
   logic                done;
   logic [15:0]         pkt_cnt;

   modport master (
      output req0, req1, data0, data1, line_valid,
      input  ack0, ack1, tx_data, tx_busy, tx_owner, done, pkt_cnt
   );

   modport slave (
      input  req0, req1, data0, data1, line_valid,
      output ack0, ack1, tx_data, tx_busy, tx_owner, done, pkt_cnt
   );
endinterface

// File: rtl/mipi_tx_arbiter.sv
// mipi_tx_arbiter
//   Round-robin share of one MIPI CSI-2 TX datapath between two requesters.
//   A granted payload is latched and sent as SYNC_WORDS sync words
//   (0x7E7E7E7E7E7E) followed by ceil(DLEN/6) 48-bit payload words, each
//   word advancing on an edge with line_valid = 1.
//   tx_pixel_clk : sole clock (rising edge)
//   rst_n        : asynchronous active-low reset
//   bus          : mipi_tx_arbiter_if.slave (requests, payloads, pacing, TX outputs)
module mipi_tx_arbiter #(
   parameter int DLEN       = 512,
   parameter int SYNC_WORDS = 2
) (
   input  logic             tx_pixel_clk,
   input  logic             rst_n,
   mipi_tx_arbiter_if.slave bus
);
   localparam int NW   = (DLEN + 5) / 6;
   localparam int PW   = NW * 48;
   localparam int MAXC = (NW > SYNC_WORDS) ? NW : SYNC_WORDS;
   localparam int IW   = $clog2(MAXC + 1);
   localparam logic [47:0] SYNC_PAT = 48'h7E7E7E7E7E7E;

   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA} state_t;

   state_t              state_q, state_d;
   logic [IW-1:0]       idx_q;
   logic [NW-1:0][47:0] buf_q;
   logic                last_owner_q;
   logic                owner_q;
   logic                ack0_q, ack1_q, done_q;
   logic [15:0]         pkt_cnt_q;
   logic                gnt_vld, gnt_idx;
   logic                sync_last, data_last;
   logic [47:0]         word_sel;

   // Tie goes to whoever did not own the datapath last.
   always_comb begin
      gnt_vld   = bus.req0 | bus.req1;
      gnt_idx   = (bus.req0 & bus.req1) ? ~last_owner_q : bus.req1;
      sync_last = (idx_q == IW'(SYNC_WORDS - 1));
      data_last = (idx_q == IW'(NW - 1));
      state_d   = state_q;
      unique case (state_q)
         S_IDLE:  if (gnt_vld) state_d = S_SYNC;
         S_SYNC:  if (bus.line_valid && sync_last) state_d = S_DATA;
         S_DATA:  if (bus.line_valid && data_last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         last_owner_q <= 1'b1;
         owner_q      <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         done_q       <= 1'b0;
         pkt_cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         done_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (gnt_vld) begin
                  ack0_q       <= ~gnt_idx;
                  ack1_q       <= gnt_idx;
                  owner_q      <= gnt_idx;
                  last_owner_q <= gnt_idx;
                  idx_q        <= '0;
               end
            end
            S_SYNC: begin
               if (bus.line_valid) idx_q <= sync_last ? '0 : idx_q + 1'b1;
            end
            S_DATA: begin
               if (bus.line_valid) begin
                  if (data_last) begin
                     idx_q     <= '0;
                     done_q    <= 1'b1;
                     pkt_cnt_q <= pkt_cnt_q + 1'b1;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Payload buffer has no reset; the zero-extension supplies the padding of
   // the last word when DLEN is not a multiple of 6.
   always_ff @(posedge tx_pixel_clk) begin
      if (state_q == S_IDLE && gnt_vld)
         buf_q <= PW'(gnt_idx ? bus.data1 : bus.data0);
   end

   always_comb begin
      word_sel = '0;
      for (int k = 0; k < NW; k++)
         if (idx_q == IW'(k)) word_sel = buf_q[k];
   end

   // Driven only from registered state, never from line_valid or requests.
   always_comb begin
      bus.tx_data = '0;
      unique case (state_q)
         S_SYNC:  bus.tx_data = {16'h0, SYNC_PAT};
         S_DATA:  bus.tx_data = {16'h0, word_sel};
         default: bus.tx_data = '0;
      endcase
   end

   assign bus.tx_busy  = (state_q != S_IDLE);
   assign bus.tx_owner = owner_q;
   assign bus.ack0     = ack0_q;
   assign bus.ack1     = ack1_q;
   assign bus.done     = done_q;
   assign bus.pkt_cnt  = pkt_cnt_q;
endmodule

// File: doc/mipi_tx_arbiter.md
# mipi_tx_arbiter

Shares the single MIPI CSI-2 TX datapath between two payload requesters (e.g. job dispatch and result return). Round-robin arbitration picks one requester, latches its DLEN-byte payload, and streams it as a framed packet onto the TX pixel bus. Each packet is two 48-bit sync words (0x7E7E7E7E7E7E) followed by the payload in 48-bit words. Word advance is paced by the line-valid qualifier from the video timing generator. The block sits between the payload producers and the `my_mipi_tx_DATA` input of the MIPI TX instance.

## Interface

Parameters:
- `DLEN`, 512: payload length in bytes; must be ≥ 1.
- `SYNC_WORDS`, 2: number of sync words sent before the payload; must be ≥ 1.
- Derived, not overridable: `NW = ceil(DLEN/6)` data words per packet (86 for DLEN = 512).

Ports:
- `tx_pixel_clk`, in, 1: sole clock; all logic on its rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `req0`, `req1`, in, 1: requests; held high until the matching ack.
- `data0`, `data1`, in, DLEN*8: payloads. Byte i is bits [8i+7:8i]. Must be stable on the cycle the request is granted.
- `line_valid`, in, 1: active-video qualifier. A word is consumed on each edge where this is 1.
- `ack0`, `ack1`, out, 1: one-cycle pulse confirming the payload was latched.
- `tx_data`, out, 64: word to the MIPI TX. Bits [63:48] are always 0.
- `tx_busy`, out, 1: high while a packet is in flight (SYNC or DATA state).
- `tx_owner`, out, 1: index of the current or last granted requester.
- `done`, out, 1: one-cycle pulse after the last data word is consumed.
- `pkt_cnt`, out, 16: count of completed packets; wraps from 0xFFFF to 0.

## Operation

**States:** IDLE, SYNC, DATA.

**IDLE**
- If neither request is high, remain in IDLE.
- If exactly one request is high, grant it.
- If both are high, grant the requester that is not `last_owner`.
- On the grant edge:
  - latch the granted `dataN` into the DLEN*8 payload buffer;
  - set `tx_owner` and `last_owner` to the granted index;
  - clear the word index;
  - go to SYNC.

**SYNC**
- `tx_data` = {16'h0, 48'h7E7E7E7E7E7E} in every cycle of this state.
- Each edge with `line_valid`=1 increments the index.
- On the edge consuming sync word `SYNC_WORDS`-1, clear the index and go to DATA.

**DATA**
- `tx_data` = {16'h0, bytes 6k+5 … 6k} of the buffer, where k is the word index; byte 6k sits in bits [7:0].
- Bytes at positions ≥ DLEN read as 0 (zero-padded last word).
- Each edge with `line_valid`=1 increments k.
- On the edge consuming word NW-1:
  - go to IDLE;
  - increment `pkt_cnt`;
  - pulse `done` in the following cycle.

**Pausing**
- While `line_valid`=0 in SYNC or DATA, the state and index hold and the same word stays on `tx_data`.
- Pauses of any length are lossless.

**Idle output:** `tx_data` is 0 in IDLE.

**Output registration**
- `tx_data` is a combinational mux of the registered state, index and buffer. It never depends combinationally on `line_valid` or the request inputs.
- `tx_busy` is a decode of the state.
- `ack0`, `ack1`, `done`, `tx_owner` and `pkt_cnt` are registered.

## Timing

- **Reset values:**
  - state = IDLE, index = 0;
  - `last_owner` = 1, so req0 wins the first tie;
  - all outputs = 0: `ack0`, `ack1`, `done`, `tx_busy`, `tx_owner`, `tx_data`, `pkt_cnt`.
  - The payload buffer is not reset.
- **Ack:** high for exactly the one cycle after the grant edge, coincident with the first SYNC cycle.
- **Request release:** the requester deasserts `req` on seeing ack. If `req` is still high when back in IDLE, it is treated as a new request.
- **Minimum packet duration:** `SYNC_WORDS` + NW cycles with `line_valid` held at 1.
- **Packet gap:** `done` coincides with the IDLE cycle. A pending request is granted on that same edge, so there is a 1-cycle IDLE gap between back-to-back packets.
- **Input isolation:** `dataN` and requests are ignored outside IDLE. A changing payload during transmission does not affect the packet.
- **Reset mid-packet:** outputs drop to reset values asynchronously and the packet is abandoned. No `done` is issued and `pkt_cnt` is not incremented.

## Test plan

1. **Reset values:** assert `rst_n`=0 mid-run → all outputs 0 immediately; after release with no requests → `tx_data` = 0 and `tx_busy` = 0 indefinitely.
2. **Single request, DLEN=12, `line_valid`=1:**
   - Stimulus: raise req0 with bytes 0x01..0x0C.
   - Required: `ack0` pulses for one cycle.
   - Required `tx_data` sequence: 7E7E7E7E7E7E, 7E7E7E7E7E7E, 060504030201, 0C0B0A090807.
   - Then `done` pulses once, `pkt_cnt` = 1, `tx_owner` = 0.
3. **Simultaneous requests:**
   - Stimulus: req0 and req1 high together after reset, each re-raised after its own ack.
   - Required: grants alternate 0, 1, 0, 1 over four packets.
   - Required: ack of the second requester arrives 2 + NW + 1 cycles after the first.
4. **Line-valid gaps:**
   - Stimulus: `line_valid` pattern 1,0,0,1,0,1,… during DATA.
   - Required: `tx_data` holds its word through each gap.
   - Required: every word appears exactly once on cycles with `line_valid`=1, with no skips or repeats.
5. **DLEN=512 padding:**
   - Required: exactly 86 data words.
   - Required: the last word has bytes 510 and 511 in bits [15:0], and bits [47:16] = 0.
   - Required: changing `data0` during DATA does not alter the output.
6. **Reset mid-DATA:**
   - Stimulus: assert reset at word 40.
   - Required: `tx_busy` = 0, `tx_data` = 0, no `done`, `pkt_cnt` = 0.
   - Required: the next req1 produces a full packet from sync word 0.
